// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider with glitch-free divide-factor changes at period boundaries.
// Optional tick counter output enabled by defining CLK_DIV_CTRL_TICKCNT_EN.
module clk_div_ctrl #(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned DEFAULT_DIV   = 2
`ifdef CLK_DIV_CTRL_TICKCNT_EN
  , parameter int unsigned TICKCNT_WIDTH = 32
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CNT_WIDTH-1:0]     div_in,
  input  logic                     div_valid,
  output logic                     div_ready,
  output logic                     clk_out,
  output logic                     tick,
  output logic                     busy,
  output logic                     err
`ifdef CLK_DIV_CTRL_TICKCNT_EN
  , output logic [TICKCNT_WIDTH-1:0] tick_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, SWITCH} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] div_reg;
  logic [CNT_WIDTH-1:0] pending;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] half;
  logic                 hs;
  logic                 legal;
  logic                 boundary;

  assign hs       = div_valid && div_ready;
  assign legal    = (div_in >= CNT_WIDTH'(2));
  assign half     = div_reg >> 1;
  assign boundary = (state != IDLE) && (cnt == div_reg);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      div_reg   <= CNT_WIDTH'(DEFAULT_DIV);
      pending   <= '0;
      cnt       <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      div_ready <= 1'b1;
      err       <= 1'b0;
    end else begin
      tick <= 1'b0;
      err  <= hs && !legal;
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          cnt     <= '0;
          if (hs && legal) div_reg <= div_in;
          if (en) begin
            state <= RUN;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        RUN, SWITCH: begin
          if (boundary) begin
            clk_out <= 1'b0;
            tick    <= 1'b1;
            cnt     <= CNT_WIDTH'(1);
            if (state == SWITCH) begin
              div_reg   <= pending;
              div_ready <= 1'b1;
            end
            // Stopping at this boundary: a value accepted now goes straight to div_reg.
            if (!en) begin
              state <= IDLE;
              cnt   <= '0;
              if (hs && legal) div_reg <= div_in;
            end else if (hs && legal) begin
              pending   <= div_in;
              div_ready <= 1'b0;
              state     <= SWITCH;
            end else begin
              state <= RUN;
            end
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt == half) clk_out <= 1'b1;
            if (hs && legal) begin
              pending   <= div_in;
              div_ready <= 1'b0;
              state     <= SWITCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_TICKCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          tick_count <= '0;
    else if (boundary) tick_count <= tick_count + TICKCNT_WIDTH'(1);
  end
`endif

endmodule
